// File: rtl/conv_ofmap_tx.sv
// Output-side transmitter of a conv layer: reads bit-sliced CIM output columns, shift-adds
// slices per output channel, sums vertical tiles, saturates and writes one pixel downstream.
module conv_ofmap_tx #(
  parameter int unsigned output_size          = 10,
  parameter int unsigned xbar_size            = 256,
  parameter int unsigned datatype_size        = 2,
  parameter int unsigned output_datatype_size = 2,
  parameter int unsigned v_cim_tiles          = 1,
  parameter int unsigned h_cim_tiles          =
      (output_size * datatype_size + xbar_size - 1) / xbar_size
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     i_start,
  input  logic                                                     i_cim_busy,
  input  logic                                                     i_next_busy,
  input  logic [v_cim_tiles-1:0][h_cim_tiles-1:0][datatype_size-1:0] i_data,
  output logic [$clog2(xbar_size)-1:0]                             o_cim_rd_addr,
  output logic                                                     o_busy,
  output logic [output_size-1:0]                                   o_ibuf_we,
  output logic [output_size-1:0][output_datatype_size-1:0]         o_ibuf_wr_data,
  output logic                                                     o_done
);

  localparam int unsigned AW    = $clog2(xbar_size);
  localparam int unsigned HW    = (h_cim_tiles > 1) ? $clog2(h_cim_tiles) : 1;
  localparam int unsigned CW    = (output_size > 1) ? $clog2(output_size) : 1;
  localparam int unsigned KW    = (datatype_size > 1) ? $clog2(datatype_size) : 1;
  localparam int unsigned VW    = $clog2(v_cim_tiles);
  localparam int unsigned ACC_W = 2 * datatype_size + VW + 1;
  localparam int unsigned SUM_W = datatype_size + VW + 1;
  localparam int unsigned WIDE_W = ACC_W + output_datatype_size;

  localparam logic [WIDE_W-1:0] SAT_MAX =
      {{ACC_W{1'b0}}, {output_datatype_size{1'b1}}};

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StWrite} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [HW-1:0]   h_q;
  logic [CW-1:0]   c_q;
  logic [KW-1:0]   k_q;

  // One-deep pipe tagging the word returning from the output buffer this cycle.
  logic            pipe_vld_q;
  logic [HW-1:0]   pipe_h_q;
  logic [CW-1:0]   pipe_c_q;
  logic [KW-1:0]   pipe_k_q;

  logic [ACC_W-1:0] acc_q [output_size];
  logic [ACC_W-1:0] acc_d [output_size];
  logic [SUM_W-1:0] tile_sum;
  logic [ACC_W-1:0] addend;

  logic [output_size-1:0][output_datatype_size-1:0] wr_data_q;

  logic last_col;
  logic write_fire;

  function automatic logic [output_datatype_size-1:0] saturate(input logic [ACC_W-1:0] a);
    logic [WIDE_W-1:0] wide;
    wide = {{output_datatype_size{1'b0}}, a};
    if (wide > SAT_MAX) begin
      return {output_datatype_size{1'b1}};
    end
    return wide[output_datatype_size-1:0];
  endfunction

  // Sum the returning slice across vertical tiles and weight it by its bit position.
  always_comb begin
    tile_sum = '0;
    for (int v = 0; v < int'(v_cim_tiles); v++) begin
      tile_sum = tile_sum + SUM_W'(i_data[v][pipe_h_q]);
    end
    addend = ACC_W'(tile_sum) << pipe_k_q;
    for (int c = 0; c < int'(output_size); c++) begin
      acc_d[c] = acc_q[c];
      if (pipe_vld_q && (pipe_c_q == CW'(c))) begin
        acc_d[c] = acc_q[c] + addend;
      end
    end
  end

  assign last_col = (c_q == CW'(output_size - 1)) && (k_q == KW'(datatype_size - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      h_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      pipe_vld_q <= 1'b0;
      pipe_h_q   <= '0;
      pipe_c_q   <= '0;
      pipe_k_q   <= '0;
      wr_data_q  <= '0;
      for (int c = 0; c < int'(output_size); c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      pipe_vld_q <= 1'b0;
      for (int c = 0; c < int'(output_size); c++) begin
        acc_q[c] <= acc_d[c];
      end
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q <= StRead;
            addr_q  <= '0;
            h_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
          end
        end
        StRead: begin
          if (!i_cim_busy) begin
            pipe_vld_q <= 1'b1;
            pipe_h_q   <= h_q;
            pipe_c_q   <= c_q;
            pipe_k_q   <= k_q;
            if (last_col) begin
              state_q <= StDrain;
            end else begin
              if (k_q == KW'(datatype_size - 1)) begin
                k_q <= '0;
                c_q <= c_q + CW'(1);
              end else begin
                k_q <= k_q + KW'(1);
              end
              if (addr_q == AW'(xbar_size - 1)) begin
                addr_q <= '0;
                h_q    <= h_q + HW'(1);
              end else begin
                addr_q <= addr_q + AW'(1);
              end
            end
          end
        end
        StDrain: begin
          // acc_d already holds the final slice captured this cycle.
          for (int c = 0; c < int'(output_size); c++) begin
            wr_data_q[c] <= saturate(acc_d[c]);
          end
          state_q <= StWrite;
        end
        StWrite: begin
          if (!i_next_busy) begin
            for (int c = 0; c < int'(output_size); c++) begin
              acc_q[c] <= '0;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The strobe must land in the same cycle the downstream drops busy, so it is decoded
  // from the registered state and the live i_next_busy.
  assign write_fire     = (state_q == StWrite) && !i_next_busy;
  assign o_ibuf_we      = {output_size{write_fire}};
  assign o_done         = write_fire;
  assign o_ibuf_wr_data = wr_data_q;
  assign o_cim_rd_addr  = addr_q;
  assign o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_conv_ofmap_tx.sv
// Self-checking bench for conv_ofmap_tx: a default-sized instance and a small multi-tile
// instance, both fed from behavioural output-buffer memories and checked against a model.
`timescale 1ns/1ps
module tb_conv_ofmap_tx;

  localparam int N_A  = 20;  // 10 channels x 2 slices
  localparam int XB_A = 256;
  localparam int N_B  = 6;   // 3 channels x 2 slices
  localparam int XB_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic                 start_a, cb_a, nb_a;
  logic [0:0][0:0][1:0] data_a;
  logic [7:0]           addr_a;
  logic                 busy_a, done_a;
  logic [9:0]           we_a;
  logic [9:0][1:0]      wd_a;
  int                   mem_a [XB_A];

  // Instance B: 3 channels, 4-column crossbar, two horizontal and two vertical tiles
  logic                 start_b, cb_b, nb_b;
  logic [1:0][1:0][1:0] data_b;
  logic [1:0]           addr_b;
  logic                 busy_b, done_b;
  logic [2:0]           we_b;
  logic [2:0][3:0]      wd_b;
  int                   mem_b [2][2][XB_B];

  int checks = 0;
  int failures = 0;

  conv_ofmap_tx u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start_a),
    .i_cim_busy     (cb_a),
    .i_next_busy    (nb_a),
    .i_data         (data_a),
    .o_cim_rd_addr  (addr_a),
    .o_busy         (busy_a),
    .o_ibuf_we      (we_a),
    .o_ibuf_wr_data (wd_a),
    .o_done         (done_a)
  );

  conv_ofmap_tx #(
    .output_size          (3),
    .xbar_size            (4),
    .datatype_size        (2),
    .output_datatype_size (4),
    .v_cim_tiles          (2),
    .h_cim_tiles          (2)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start_b),
    .i_cim_busy     (cb_b),
    .i_next_busy    (nb_b),
    .i_data         (data_b),
    .o_cim_rd_addr  (addr_b),
    .o_busy         (busy_b),
    .o_ibuf_we      (we_b),
    .o_ibuf_wr_data (wd_b),
    .o_done         (done_b)
  );

  // Output buffers with one-cycle read latency.
  always @(posedge clk) begin
    data_a[0][0] <= 2'(mem_a[addr_a]);
    for (int v = 0; v < 2; v++) begin
      for (int h = 0; h < 2; h++) begin
        data_b[v][h] <= 2'(mem_b[v][h][addr_b]);
      end
    end
  end

  // Reference: channel c owns global columns c*2+k; column g lives in tile g/xbar at g%xbar.
  function automatic int model_a(input int c);
    int s = 0;
    for (int k = 0; k < 2; k++) s += mem_a[(c * 2 + k) % XB_A] * (1 << k);
    return (s > 3) ? 3 : s;
  endfunction

  function automatic int model_b(input int c);
    int s = 0;
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v < 2; v++) begin
        s += mem_b[v][(c * 2 + k) / XB_B][(c * 2 + k) % XB_B] * (1 << k);
      end
    end
    return (s > 15) ? 15 : s;
  endfunction

  // One transaction on A; stall windows are given in cycles counted from the start edge.
  task automatic run_a(input int cb_at, input int cb_len, input int nb_len, input bit hold_start);
    int issued = 0;
    int pulse_at = N_A + cb_len + 2 + nb_len;
    bit fire;
    @(posedge clk); #1 start_a = 1'b1;
    for (int n = 1; n <= pulse_at + 1; n++) begin
      @(posedge clk); #1;
      start_a = hold_start && (n < pulse_at);
      cb_a    = (n >= cb_at) && (n < cb_at + cb_len);
      nb_a    = (n >= N_A + cb_len + 2) && (n < pulse_at);
      @(negedge clk);
      fire = (n == pulse_at);
      checks++;
      if (busy_a !== (n <= pulse_at)) begin
        failures++;
        $display("FAIL a_busy cycle %0d: got %b want %b", n, busy_a, (n <= pulse_at));
      end
      if (n <= N_A + cb_len) begin
        checks++;
        if (addr_a !== 8'(issued % XB_A)) begin
          failures++;
          $display("FAIL a_addr cycle %0d: got %0d want %0d", n, addr_a, issued % XB_A);
        end
        if (!cb_a) issued++;
      end
      checks++;
      if ({done_a, we_a} !== {fire, {10{fire}}}) begin
        failures++;
        $display("FAIL a_strobe cycle %0d: got done=%b we=%h want %b", n, done_a, we_a, fire);
      end
      if (n >= pulse_at) begin
        for (int c = 0; c < 10; c++) begin
          checks++;
          if (wd_a[c] !== 2'(model_a(c))) begin
            failures++;
            $display("FAIL a_data cycle %0d ch %0d: got %0d want %0d", n, c, wd_a[c], model_a(c));
          end
        end
      end
    end
    start_a = 1'b0;
  endtask

  task automatic run_b();
    int pulse_at = N_B + 2;
    bit fire;
    @(posedge clk); #1 start_b = 1'b1;
    for (int n = 1; n <= pulse_at + 1; n++) begin
      @(posedge clk); #1 start_b = 1'b0;
      @(negedge clk);
      fire = (n == pulse_at);
      checks++;
      if (busy_b !== (n <= pulse_at)) begin
        failures++;
        $display("FAIL b_busy cycle %0d: got %b want %b", n, busy_b, (n <= pulse_at));
      end
      if (n <= N_B) begin
        checks++;
        if (addr_b !== 2'((n - 1) % XB_B)) begin
          failures++;
          $display("FAIL b_addr cycle %0d: got %0d want %0d", n, addr_b, (n - 1) % XB_B);
        end
      end
      checks++;
      if ({done_b, we_b} !== {fire, {3{fire}}}) begin
        failures++;
        $display("FAIL b_strobe cycle %0d: got done=%b we=%b want %b", n, done_b, we_b, fire);
      end
      if (fire) begin
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (wd_b[c] !== 4'(model_b(c))) begin
            failures++;
            $display("FAIL b_data ch %0d: got %0d want %0d", c, wd_b[c], model_b(c));
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({addr_a, busy_a, we_a, wd_a, done_a} !== '0 || {addr_b, busy_b, we_b, wd_b, done_b} !== '0)
    begin
      failures++;
      $display("FAIL reset_state: got a=%h b=%h want 0", {addr_a, busy_a, we_a, wd_a, done_a},
               {addr_b, busy_b, we_b, wd_b, done_b});
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < XB_A; i++) mem_a[i] = 1;
    run_a(0, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < XB_A; i++) mem_a[i] = (i % 2 == 0) ? 1 : 0;
    run_a(0, 0, 0, 1'b0);
    for (int i = 0; i < XB_A; i++) mem_a[i] = (i % 2 == 0) ? 2 : 1;
    run_a(0, 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < XB_A; i++) mem_a[i] = $urandom_range(0, 3);
    run_a(6, 3, 5, 1'b0);
  endtask

  task automatic test_random_a();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < XB_A; i++) mem_a[i] = $urandom_range(0, 3);
      run_a($urandom_range(1, 15), $urandom_range(0, 4), $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < XB_A; i++) mem_a[i] = $urandom_range(0, 3);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({addr_a, busy_a, we_a, wd_a, done_a} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h want 0", {addr_a, busy_a, we_a, wd_a, done_a});
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      checks++;
      if ({done_a, we_a, busy_a} !== '0) begin
        failures++;
        $display("FAIL reset_mid_quiet cycle %0d: got %h want 0", n, {done_a, we_a, busy_a});
      end
    end
    for (int i = 0; i < XB_A; i++) mem_a[i] = $urandom_range(0, 3);
    run_a(0, 0, 0, 1'b0);
  endtask

  task automatic test_tiles();
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < 2; h++)
        for (int a = 0; a < XB_B; a++)
          mem_b[v][h][a] = (v == 0 && h == 1 && a == 0) ? 1 : 0;
    run_b();
  endtask

  task automatic test_vsum();
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < 2; h++)
        for (int a = 0; a < XB_B; a++) mem_b[v][h][a] = 1;
    run_b();
  endtask

  task automatic test_random_b();
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 2; v++)
        for (int h = 0; h < 2; h++)
          for (int a = 0; a < XB_B; a++) mem_b[v][h][a] = $urandom_range(0, 3);
      run_b();
    end
  endtask

  initial begin
    {start_a, cb_a, nb_a, start_b, cb_b, nb_b} = '0;
    for (int i = 0; i < XB_A; i++) mem_a[i] = 0;
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < 2; h++)
        for (int a = 0; a < XB_B; a++) mem_b[v][h][a] = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_random_a();
    test_reset_mid();
    test_tiles();
    test_vsum();
    test_random_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
